// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: grants the shared datapath bus to one source at a time and drives the
// one-hot gate enables, holding MDR grants in a memory-ready wait with timeout abort.
module bus_gate_arbiter #(
    parameter bit RR_EN       = 1'b1,
    parameter int MDR_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reqMARM,
    input  logic       reqPC,
    input  logic       reqALU,
    input  logic       reqMDR,
    input  logic       memR,
    output logic       enaMARM,
    output logic       enaPC,
    output logic       enaALU,
    output logic       enaMDR,
    output logic       busBusy,
    output logic       grantDone,
    output logic       errTimeout,
    output logic [1:0] lastGrant
);
    typedef enum logic [1:0] {IDLE, XFER, WAIT_MEM} state_t;
    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d, last_q, last_d, base, win, idx;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] ena_q, ena_d, req_m;
    logic       busy_q, busy_d, done_q, done_d, err_q, err_d, hit;

    always_comb begin
        // the grantee finishing this cycle drops its request on grantDone, so ignore it now
        req_m = {reqMDR, reqALU, reqPC, reqMARM} & ((state_q == XFER) ? ~(4'b0001 << gnt_q) : 4'b1111);
        base = RR_EN ? ((state_q == XFER) ? gnt_q : last_q) + 2'd1 : 2'd0;
        win = base;
        hit = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (req_m[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
        state_d = state_q;
        gnt_d = gnt_q;
        last_d = last_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (state_q == WAIT_MEM) begin
            if (!reqMDR) begin
                state_d = IDLE;
            end else if (memR) begin
                state_d = XFER;
            end else if (9'(cnt_q) + 9'd1 >= 9'(MDR_TIMEOUT)) begin
                state_d = IDLE;
                err_d = 1'b1;
                last_d = 2'd3;
            end else begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end
        end else begin
            last_d = (state_q == XFER) ? gnt_q : last_q;
            state_d = hit ? ((win == 2'd3) ? WAIT_MEM : XFER) : IDLE;
            gnt_d = hit ? win : gnt_q;
            cnt_d = 8'd0;
        end
        ena_d = (state_d == XFER) ? 4'b0001 << gnt_d : 4'b0000;
        busy_d = state_d != IDLE;
        done_d = state_d == XFER;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q <= 2'd0;
            last_q <= 2'd3;
            cnt_q <= 8'd0;
            ena_q <= 4'b0000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            ena_q <= ena_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end

    assign {enaMDR, enaALU, enaPC, enaMARM} = ena_q;
    assign busBusy = busy_q;
    assign grantDone = done_q;
    assign errTimeout = err_q;
    assign lastGrant = last_q;
endmodule

// File: tb/tb_bus_gate_arbiter.sv
// tb_bus_gate_arbiter: round-robin and fixed-priority instances share stimulus; a reference
// model queues expected output events per instance and a monitor pops and compares them.
module tb_bus_gate_arbiter;
    localparam int TMO = 15;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       mem_r = 1'b0;
    logic [3:0] ena_rr, ena_fp;
    logic       busy_rr, busy_fp, done_rr, done_fp, err_rr, err_fp;
    logic [1:0] last_rr, last_fp;
    int         cyc = 0, total = 0, pass = 0;

    typedef struct {int t; logic [3:0] ena; logic busy, done, err; logic [1:0] last;} exp_t;
    exp_t q0[$], q1[$];
    // model: state 0 idle, 1 transferring, 2 waiting for memory
    int   ms[2], mg[2], ml[2], mw[2];
    logic merr[2];

    logic [3:0] t2_r[9] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
    logic       t2_m[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] t2_e[9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_gate_arbiter #(.RR_EN(1'b1), .MDR_TIMEOUT(TMO)) u_rr (
        .clk(clk), .rst_n(rst_n), .reqMARM(req[0]), .reqPC(req[1]), .reqALU(req[2]), .reqMDR(req[3]),
        .memR(mem_r), .enaMARM(ena_rr[0]), .enaPC(ena_rr[1]), .enaALU(ena_rr[2]), .enaMDR(ena_rr[3]),
        .busBusy(busy_rr), .grantDone(done_rr), .errTimeout(err_rr), .lastGrant(last_rr));
    bus_gate_arbiter #(.RR_EN(1'b0), .MDR_TIMEOUT(TMO)) u_fp (
        .clk(clk), .rst_n(rst_n), .reqMARM(req[0]), .reqPC(req[1]), .reqALU(req[2]), .reqMDR(req[3]),
        .memR(mem_r), .enaMARM(ena_fp[0]), .enaPC(ena_fp[1]), .enaALU(ena_fp[2]), .enaMDR(ena_fp[3]),
        .busBusy(busy_fp), .grantDone(done_fp), .errTimeout(err_fp), .lastGrant(last_fp));

    task automatic cmp(input string name, input int act, input int want);
        total++;
        if (act == want) pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    task automatic qpush(input int d, input exp_t x);
        if (d == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    function automatic int qsize(input int d);
        return d == 0 ? q0.size() : q1.size();
    endfunction

    function automatic int qfront_t(input int d);
        return d == 0 ? q0[0].t : q1[0].t;
    endfunction

    task automatic qpop(input int d, output exp_t x);
        if (d == 0) x = q0.pop_front();
        else x = q1.pop_front();
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ms[d] = 0; mg[d] = 0; ml[d] = 3; mw[d] = 0; merr[d] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // advance instance d across one edge with inputs r_in/mr; queue what it shows afterwards
    task automatic model_step(input int d, input logic [3:0] r_in, input logic mr);
        logic [3:0] r;
        int         start;
        exp_t       x;
        r = r_in;
        merr[d] = 1'b0;
        if (ms[d] == 2) begin
            mw[d]++;
            if (!r[3]) ms[d] = 0;
            else if (mr) ms[d] = 1;
            else if (mw[d] == TMO) begin
                merr[d] = 1'b1; ml[d] = 3; ms[d] = 0;
            end
        end else begin
            if (ms[d] == 1) begin
                r[mg[d]] = 1'b0;
                ml[d] = mg[d];
            end
            start = (d == 0) ? (ml[d] + 1) % 4 : 0;
            ms[d] = 0;
            for (int k = 0; k < 4; k++)
                if (ms[d] == 0 && r[(start + k) % 4]) begin
                    mg[d] = (start + k) % 4;
                    ms[d] = (mg[d] == 3) ? 2 : 1;
                    mw[d] = 0;
                end
        end
        if (ms[d] != 0 || merr[d]) begin
            x.t = cyc + 1;
            x.ena = (ms[d] == 1) ? 4'(1 << mg[d]) : 4'b0000;
            x.busy = ms[d] != 0;
            x.done = ms[d] == 1;
            x.err = merr[d];
            x.last = 2'(ml[d]);
            qpush(d, x);
        end
    endtask

    task automatic apply(input logic [3:0] r, input logic mr);
        req = r;
        mem_r = mr;
        model_step(0, r, mr);
        model_step(1, r, mr);
    endtask

    task automatic drive(input logic [3:0] r, input logic mr);
        @(posedge clk);
        #1;
        apply(r, mr);
    endtask

    // called 1 time unit after an edge; asserts reset between edges
    task automatic do_reset(input logic [3:0] r, input logic mr);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("rst_ena_rr", ena_rr, 0);   cmp("rst_ena_fp", ena_fp, 0);
        cmp("rst_busy_rr", busy_rr, 0); cmp("rst_busy_fp", busy_fp, 0);
        cmp("rst_done_rr", done_rr, 0); cmp("rst_done_fp", done_fp, 0);
        cmp("rst_err_rr", err_rr, 0);   cmp("rst_err_fp", err_fp, 0);
        cmp("rst_last_rr", last_rr, 3); cmp("rst_last_fp", last_fp, 3);
        model_reset();
        req = r;
        mem_r = mr;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_step(0, r, mr);
        model_step(1, r, mr);
    endtask

    task automatic check(input int d);
        logic [3:0] e;
        logic       b, g, er;
        logic [1:0] l;
        exp_t       x;
        e = d == 0 ? ena_rr : ena_fp;
        b = d == 0 ? busy_rr : busy_fp;
        g = d == 0 ? done_rr : done_fp;
        er = d == 0 ? err_rr : err_fp;
        l = d == 0 ? last_rr : last_fp;
        while (qsize(d) > 0 && qfront_t(d) < cyc) begin
            qpop(d, x);
            total++;
            $display("FAIL missed_event dut%0d cycle %0d: no output seen, expected ena=%b busy=%b err=%b",
                     d, x.t, x.ena, x.busy, x.err);
        end
        if (e != 4'b0000 || b || g || er) begin
            total++;
            if (qsize(d) == 0) begin
                $display("FAIL unexpected_event dut%0d cycle %0d: got ena=%b busy=%b done=%b err=%b last=%0d, expected no activity",
                         d, cyc, e, b, g, er, l);
            end else begin
                qpop(d, x);
                if (x.t == cyc && x.ena == e && x.busy == b && x.done == g && x.err == er && x.last == l
                    && $countones(e) <= 1)
                    pass++;
                else
                    $display("FAIL event dut%0d cycle %0d: got ena=%b busy=%b done=%b err=%b last=%0d, expected cycle %0d ena=%b busy=%b done=%b err=%b last=%0d",
                             d, cyc, e, b, g, er, l, x.t, x.ena, x.busy, x.done, x.err, x.last);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        if (rst_n) begin
            check(0);
            check(1);
        end
    end

    initial begin
        logic [3:0] r;
        logic       mr;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(4'b0000, 1'b0);
        repeat (3) drive(4'b0000, 1'b0);
        // all four requesters, each dropping on its own grant
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            cmp("t2_ena_rr", ena_rr, t2_e[i]);
            cmp("t2_ena_fp", ena_fp, t2_e[i]);
            apply(t2_r[i], t2_m[i]);
        end
        cmp("t2_last_rr", last_rr, 3);
        // PC and ALU held continuously alternate under masking
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                cmp("t3_grant_fp", ena_fp, (i % 2) ? 2 : 4);
                cmp("t3_grant_rr", ena_rr, (i % 2) ? 2 : 4);
            end
            apply(i < 8 ? 4'b0110 : 4'b0000, 1'b0);
        end
        // MDR alone, memory never ready
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) begin
                cmp("t4_busy_last_wait", busy_rr, 1);
                cmp("t4_no_early_err", err_rr, 0);
            end
            if (i == 16) begin
                cmp("t4_err", err_rr, 1);
                cmp("t4_busy_off", busy_rr, 0);
                cmp("t4_no_ena", ena_rr, 0);
                cmp("t4_last", last_rr, 3);
            end
            if (i == 17) cmp("t4_err_one_cycle", err_rr, 0);
            apply(i <= 15 ? 4'b1000 : 4'b0000, 1'b0);
        end
        // withdrawal beats memR on the same edge
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) cmp("t5_waiting", busy_rr, 1);
            if (i == 3) begin
                cmp("t5_busy", busy_rr, 0); cmp("t5_ena", ena_rr, 0);
                cmp("t5_done", done_rr, 0); cmp("t5_err", err_rr, 0);
            end
            apply(i < 2 ? 4'b1000 : 4'b0000, i == 2);
        end
        // reset during WAIT_MEM with memR high, then MDR re-arbitrated
        drive(4'b1000, 1'b0);
        @(posedge clk);
        #1;
        cmp("t6_wait_before_reset", busy_rr, 1);
        apply(4'b1000, 1'b1);
        do_reset(4'b1000, 1'b1);
        @(posedge clk);
        #1;
        cmp("t6_rearb_wait", busy_rr, 1);
        cmp("t6_rearb_no_ena", ena_rr, 0);
        apply(4'b1000, 1'b1);
        @(posedge clk);
        #1;
        cmp("t6_mdr_grant", ena_rr, 8);
        cmp("t6_mdr_done", done_rr, 1);
        apply(4'b0000, 1'b0);
        // random requesters that usually drop on their own grant
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            r = req;
            for (int i = 0; i < 4; i++) begin
                if (r[i] && ((ms[0] == 1 && mg[0] == i) || (ms[1] == 1 && mg[1] == i))) begin
                    if ($urandom_range(3, 0) != 0) r[i] = 1'b0;
                end else if (!r[i] && $urandom_range(2, 0) == 0) begin
                    r[i] = 1'b1;
                end
            end
            if (r[3] && (ms[0] == 2 || ms[1] == 2) && $urandom_range(15, 0) == 0) r[3] = 1'b0;
            mr = $urandom_range(5, 0) == 0;
            apply(r, mr);
            if (n == 300) do_reset(r, mr);
        end
        repeat (20) drive(4'b0000, 1'b0);
        @(posedge clk);
        #3;
        cmp("final_queue_empty", qsize(0) + qsize(1), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
